// File: rtl/pipeline_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard/sequencing controller.
package pipeline_pkg;

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    HALT     = 2'd3
  } ctrl_state_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  // Architectural zero register: never a hazard source, never forwarded.
  localparam int REG_X0 = 0;

endpackage

// File: rtl/pipeline_ctrl_forward_unit.sv
// EX-stage operand forwarding selects; purely combinational, MEM result wins over WB.
module forward_unit
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] e_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] e_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] m_rd,
  input  logic [REG_ADDR_WIDTH-1:0] w_rd,
  input  logic                      m_regwrite,
  input  logic                      w_regwrite,
  output logic [1:0]                forward_a,
  output logic [1:0]                forward_b
);

  localparam logic [REG_ADDR_WIDTH-1:0] X0 = REG_ADDR_WIDTH'(REG_X0);

  fwd_sel_e sel_a;
  fwd_sel_e sel_b;
  logic     m_live;
  logic     w_live;

  assign m_live = m_regwrite && (m_rd != X0);
  assign w_live = w_regwrite && (w_rd != X0);

  // NOTE: every variable written in an always_comb gets a default first, so no
  // path through the if/else chain can leave it unassigned and infer a latch.
  always_comb begin
    sel_a = FWD_RF;
    sel_b = FWD_RF;
    if (m_live && (m_rd == e_rs1))      sel_a = FWD_MEM;
    else if (w_live && (w_rd == e_rs1)) sel_a = FWD_WB;
    if (m_live && (m_rd == e_rs2))      sel_b = FWD_MEM;
    else if (w_live && (w_rd == e_rs2)) sel_b = FWD_WB;
  end

  assign forward_a = sel_a;
  assign forward_b = sel_b;

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller: stage enables, flushes, forwarding and memory watchdog.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MEM_TIMEOUT    = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_ADDR_WIDTH-1:0] d_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] d_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] e_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] e_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] e_rd,
  input  logic                      e_memread,
  input  logic                      e_pcsrc,
  input  logic [REG_ADDR_WIDTH-1:0] m_rd,
  input  logic [REG_ADDR_WIDTH-1:0] w_rd,
  input  logic                      m_regwrite,
  input  logic                      w_regwrite,
  input  logic                      dmem_req,
  input  logic                      dmem_ready,
  output logic                      f_en,
  output logic                      d_en,
  output logic                      e_en,
  output logic                      m_en,
  output logic                      w_en,
  output logic                      d_flush,
  output logic                      e_flush,
  output logic                      w_flush,
  output logic [1:0]                forward_a,
  output logic [1:0]                forward_b,
  output logic                      halted,
  output logic [31:0]               stall_cycles,
  output logic [31:0]               flush_count
);

  localparam int                         CNT_W    = $clog2(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0]           CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [REG_ADDR_WIDTH-1:0]  X0       = REG_ADDR_WIDTH'(REG_X0);

  ctrl_state_e      state;
  ctrl_state_e      state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_next;
  logic             mem_stall;
  logic             load_use;
  logic             pipe_go;

  assign mem_stall = dmem_req && !dmem_ready;
  assign load_use  = e_memread && (e_rd != X0) && ((e_rd == d_rs1) || (e_rd == d_rs2));

  // NOTE: sequential state uses non-blocking assignments only, and the async
  // active-low reset sits in the sensitivity list so it acts mid-cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    pipe_go       = 1'b0;
    f_en          = 1'b0;
    d_en          = 1'b0;
    e_en          = 1'b0;
    m_en          = 1'b0;
    w_en          = 1'b0;
    d_flush       = 1'b0;
    e_flush       = 1'b0;
    w_flush       = 1'b0;
    halted        = 1'b0;

    case (state)
      INIT: begin
        d_flush    = 1'b1;
        e_flush    = 1'b1;
        w_flush    = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        if (mem_stall) begin
          w_flush       = 1'b1;
          state_next    = MEM_WAIT;
          wait_cnt_next = CNT_W'(1);
        end else begin
          pipe_go = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!dmem_ready) begin
          w_flush = 1'b1;
          if (wait_cnt == CNT_LAST) state_next = HALT;
          else                      wait_cnt_next = wait_cnt + CNT_W'(1);
        end else begin
          // Access completed: behave as RUN this very cycle.
          pipe_go       = 1'b1;
          state_next    = RUN;
          wait_cnt_next = '0;
        end
      end
      HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_next = INIT;
      end
    endcase

    // A taken branch outranks a load-use hazard in the same cycle.
    if (pipe_go) begin
      if (e_pcsrc) begin
        f_en    = 1'b1;
        d_en    = 1'b1;
        e_en    = 1'b1;
        m_en    = 1'b1;
        w_en    = 1'b1;
        d_flush = 1'b1;
        e_flush = 1'b1;
      end else if (load_use) begin
        e_en    = 1'b1;
        m_en    = 1'b1;
        w_en    = 1'b1;
        e_flush = 1'b1;
      end else begin
        f_en = 1'b1;
        d_en = 1'b1;
        e_en = 1'b1;
        m_en = 1'b1;
        w_en = 1'b1;
      end
    end
  end

  forward_unit #(
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_forward_unit (
    .e_rs1     (e_rs1),
    .e_rs2     (e_rs2),
    .m_rd      (m_rd),
    .w_rd      (w_rd),
    .m_regwrite(m_regwrite),
    .w_regwrite(w_regwrite),
    .forward_a (forward_a),
    .forward_b (forward_b)
  );

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_q;
  logic [31:0] flush_q;
  logic        fetch_stalled;
  logic        branch_flush;

  assign fetch_stalled = ((state == RUN) || (state == MEM_WAIT)) && !f_en;
  assign branch_flush  = pipe_go && e_pcsrc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (fetch_stalled) stall_q <= stall_q + 32'd1;
      if (branch_flush)  flush_q <= flush_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model (memory-wait tracked as a stall-run length).
module tb_pipeline_ctrl;

  localparam int RW = 5;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [RW-1:0] d_rs1, d_rs2, e_rs1, e_rs2, e_rd, m_rd, w_rd;
  logic          e_memread, e_pcsrc, m_regwrite, w_regwrite, dmem_req, dmem_ready;
  logic          f_en, d_en, e_en, m_en, w_en, d_flush, e_flush, w_flush, halted;
  logic [1:0]    forward_a, forward_b;
  logic [31:0]   stall_cycles, flush_count;

  pipeline_ctrl #(.REG_ADDR_WIDTH(RW), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .d_rs1(d_rs1), .d_rs2(d_rs2), .e_rs1(e_rs1), .e_rs2(e_rs2), .e_rd(e_rd),
    .e_memread(e_memread), .e_pcsrc(e_pcsrc),
    .m_rd(m_rd), .w_rd(w_rd), .m_regwrite(m_regwrite), .w_regwrite(w_regwrite),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .f_en(f_en), .d_en(d_en), .e_en(e_en), .m_en(m_en), .w_en(w_en),
    .d_flush(d_flush), .e_flush(e_flush), .w_flush(w_flush),
    .forward_a(forward_a), .forward_b(forward_b), .halted(halted),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // {f,d,e,m,w enables, d/e/w flush, halted, forward_a, forward_b}
  logic [12:0] obs;
  assign obs = {f_en, d_en, e_en, m_en, w_en, d_flush, e_flush, w_flush, halted, forward_a, forward_b};

  localparam logic [12:0] OBS_INIT = 13'b00000_111_0_00_00;
  localparam logic [12:0] OBS_RUN  = 13'b11111_000_0_00_00;

  // Behavioural model state
  bit          mdl_init;
  bit          mdl_halt;
  int          mdl_wait;      // length of the current run of memory-stall cycles
  int unsigned mdl_stalls;
  int unsigned mdl_flushes;
  logic [12:0] exp_obs;
  bit          exp_mem_stall, exp_branch, exp_fstall;

  function automatic logic [1:0] fwd_ref(input logic [RW-1:0] rs);
    if (rs == 0) return 2'b00;
    if (m_regwrite && m_rd == rs) return 2'b10;
    if (w_regwrite && w_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] perf_ref(input int unsigned v);
`ifdef PIPE_PERF_CNT_EN
    return v;
`else
    return (v == 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  function automatic void model_eval();
    logic [4:0] en;
    logic [2:0] fl;
    logic       h;
    bit         hazard;
    exp_mem_stall = 0;
    exp_branch    = 0;
    exp_fstall    = 0;
    h             = 1'b0;
    if (!rst_n || mdl_init) begin
      en = '0; fl = 3'b111;
    end else if (mdl_halt) begin
      en = '0; fl = 3'b000; h = 1'b1;
    end else begin
      exp_mem_stall = (mdl_wait > 0) ? !dmem_ready : (dmem_req && !dmem_ready);
      hazard = e_memread && (e_rd != 0) && (e_rd == d_rs1 || e_rd == d_rs2);
      if (exp_mem_stall)  begin en = 5'b00000; fl = 3'b001; end
      else if (e_pcsrc)   begin en = 5'b11111; fl = 3'b110; exp_branch = 1; end
      else if (hazard)    begin en = 5'b00111; fl = 3'b010; end
      else                begin en = 5'b11111; fl = 3'b000; end
      exp_fstall = !en[4];
    end
    exp_obs = {en, fl, h, fwd_ref(e_rs1), fwd_ref(e_rs2)};
  endfunction

  task automatic model_reset();
    mdl_init = 1; mdl_halt = 0; mdl_wait = 0; mdl_stalls = 0; mdl_flushes = 0;
  endtask

  // Evaluate, clock once, update the model, return at the following negedge.
  task automatic advance();
    model_eval();
    @(posedge clk);
    if (rst_n) begin
      if (mdl_init) mdl_init = 0;
      else if (!mdl_halt) begin
        if (exp_fstall) mdl_stalls++;
        if (exp_branch) mdl_flushes++;
        if (exp_mem_stall) begin
          mdl_wait++;
          if (mdl_wait == TO) mdl_halt = 1;
        end else begin
          mdl_wait = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    d_rs1 = 0; d_rs2 = 0; e_rs1 = 0; e_rs2 = 0; e_rd = 0; m_rd = 0; w_rd = 0;
    e_memread = 0; e_pcsrc = 0; m_regwrite = 0; w_regwrite = 0;
    dmem_req = 0; dmem_ready = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (obs !== OBS_INIT) begin n_fail++; $display("FAIL reset_low: got %b want %b", obs, OBS_INIT); end
    n_checks++;
    if (stall_cycles !== 32'd0 || flush_count !== 32'd0) begin
      n_fail++; $display("FAIL reset_counters: got %0d/%0d want 0/0", stall_cycles, flush_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    model_eval();
    n_checks++;
    if (obs !== exp_obs || obs !== OBS_INIT) begin n_fail++; $display("FAIL init_cycle: got %b want %b", obs, OBS_INIT); end
    advance();
    #1;
    model_eval();
    n_checks++;
    if (obs !== exp_obs || obs !== OBS_RUN) begin n_fail++; $display("FAIL run_after_init: got %b want %b", obs, OBS_RUN); end
    advance();
  endtask

  task automatic test_load_use();
    clear_inputs();
    e_memread = 1; e_rd = 5; d_rs1 = 3; d_rs2 = 5;
    #1;
    model_eval();
    n_checks++;
    if (obs !== exp_obs || {f_en, d_en, e_flush} !== 3'b001) begin
      n_fail++; $display("FAIL load_use: got %b want %b", obs, exp_obs);
    end
    advance();
    clear_inputs();
    e_memread = 1; e_rd = 0; d_rs1 = 0; d_rs2 = 0;
    #1;
    model_eval();
    n_checks++;
    if (obs !== exp_obs || {f_en, d_en, e_flush} !== 3'b110) begin
      n_fail++; $display("FAIL load_use_x0: got %b want %b", obs, exp_obs);
    end
    advance();
  endtask

  task automatic test_branch_priority();
    clear_inputs();
    e_pcsrc = 1; e_memread = 1; e_rd = 9; d_rs1 = 9;
    #1;
    model_eval();
    n_checks++;
    if (obs !== exp_obs || {f_en, d_en, d_flush, e_flush} !== 4'b1111) begin
      n_fail++; $display("FAIL branch_over_load_use: got %b want %b", obs, exp_obs);
    end
    advance();
  endtask

  task automatic test_mem_wait();
    int unsigned sc0;
    sc0 = stall_cycles;
    clear_inputs();
    dmem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      model_eval();
      n_checks++;
      if (obs !== exp_obs || obs[12:5] !== 8'b00000_001) begin
        n_fail++; $display("FAIL mem_wait_%0d: got %b want %b", i, obs, exp_obs);
      end
      advance();
    end
    dmem_ready = 1;
    #1;
    model_eval();
    n_checks++;
    if (obs !== exp_obs || obs[12:8] !== 5'b11111) begin
      n_fail++; $display("FAIL mem_wait_release: got %b want %b", obs, exp_obs);
    end
    advance();
    clear_inputs();
    #1;
    n_checks++;
    if (stall_cycles - sc0 !== perf_ref(3) || stall_cycles !== perf_ref(mdl_stalls)) begin
      n_fail++; $display("FAIL mem_wait_stall_count: got %0d want %0d", stall_cycles, perf_ref(mdl_stalls));
    end
    n_checks++;
    if (flush_count !== perf_ref(mdl_flushes)) begin
      n_fail++; $display("FAIL flush_count: got %0d want %0d", flush_count, perf_ref(mdl_flushes));
    end
    advance();
  endtask

  task automatic test_timeout();
    clear_inputs();
    dmem_req = 1; dmem_ready = 0;
    for (int i = 0; i < TO + 2; i++) begin
      #1;
      model_eval();
      n_checks++;
      if (obs !== exp_obs) begin n_fail++; $display("FAIL timeout_cycle_%0d: got %b want %b", i, obs, exp_obs); end
      advance();
    end
    dmem_ready = 1; e_pcsrc = 1;
    #1;
    model_eval();
    n_checks++;
    if (obs !== exp_obs || halted !== 1'b1 || obs[12:5] !== 8'd0) begin
      n_fail++; $display("FAIL halt_sticky: got %b want %b", obs, exp_obs);
    end
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    model_eval();
    n_checks++;
    if (obs !== exp_obs || halted !== 1'b0 || obs[12:5] !== 8'b00000_111) begin
      n_fail++; $display("FAIL async_reset_mid_cycle: got %b want %b", obs, exp_obs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    clear_inputs();
    #1;
    model_eval();
    n_checks++;
    if (obs !== exp_obs) begin n_fail++; $display("FAIL init_after_halt: got %b want %b", obs, exp_obs); end
    advance();
    #1;
    model_eval();
    n_checks++;
    if (obs !== exp_obs || obs !== OBS_RUN) begin n_fail++; $display("FAIL run_after_halt: got %b want %b", obs, OBS_RUN); end
    advance();
  endtask

  task automatic test_forwarding();
    // {m_rd, w_rd, e_rs1, m_regwrite, w_regwrite, expected forward_a}
    logic [RW*3+3:0] tbl [6];
    tbl[0] = {5'd7, 5'd7, 5'd7, 1'b1, 1'b1, 2'b10};
    tbl[1] = {5'd7, 5'd7, 5'd7, 1'b0, 1'b1, 2'b01};
    tbl[2] = {5'd7, 5'd7, 5'd0, 1'b1, 1'b1, 2'b00};
    tbl[3] = {5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 2'b00};
    tbl[4] = {5'd3, 5'd7, 5'd7, 1'b1, 1'b1, 2'b01};
    tbl[5] = {5'd7, 5'd7, 5'd7, 1'b0, 1'b0, 2'b00};
    for (int i = 0; i < 6; i++) begin
      clear_inputs();
      {m_rd, w_rd, e_rs1, m_regwrite, w_regwrite} = tbl[i][RW*3+3:2];
      e_rs2 = e_rs1;
      #1;
      model_eval();
      n_checks++;
      if (forward_a !== tbl[i][1:0] || forward_b !== tbl[i][1:0] || obs !== exp_obs) begin
        n_fail++; $display("FAIL forward_%0d: got a=%b b=%b want %b", i, forward_a, forward_b, tbl[i][1:0]);
      end
      advance();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if (mdl_halt && ($urandom_range(0, 3) == 0)) begin
        rst_n = 1'b0;
        model_reset();
        #2;
        rst_n = 1'b1;
      end
      d_rs1 = RW'($urandom_range(0, 7)); d_rs2 = RW'($urandom_range(0, 7));
      e_rs1 = RW'($urandom_range(0, 7)); e_rs2 = RW'($urandom_range(0, 7));
      e_rd  = RW'($urandom_range(0, 7));
      m_rd  = RW'($urandom_range(0, 7)); w_rd  = RW'($urandom_range(0, 7));
      e_memread  = ($urandom_range(0, 9) < 4);
      e_pcsrc    = ($urandom_range(0, 9) < 2);
      m_regwrite = $urandom_range(0, 1);
      w_regwrite = $urandom_range(0, 1);
      dmem_req   = ($urandom_range(0, 9) < 2);
      dmem_ready = ($urandom_range(0, 9) < 6);
      #1;
      model_eval();
      n_checks++;
      if (obs !== exp_obs) begin n_fail++; $display("FAIL random_%0d: got %b want %b", i, obs, exp_obs); end
      n_checks++;
      if (stall_cycles !== perf_ref(mdl_stalls) || flush_count !== perf_ref(mdl_flushes)) begin
        n_fail++;
        $display("FAIL random_perf_%0d: got %0d/%0d want %0d/%0d", i, stall_cycles, flush_count,
                 perf_ref(mdl_stalls), perf_ref(mdl_flushes));
      end
      advance();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_load_use();
    test_branch_priority();
    test_mem_wait();
    test_timeout();
    test_forwarding();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
